// File: rtl/led_map_pkg.sv
// Shared wiring-mode constants, FSM encoding and mode decode helpers for the LED strip mapper.
package led_map_pkg;

  localparam logic [1:0] MODE_ROW      = 2'd0;
  localparam logic [1:0] MODE_ROW_SERP = 2'd1;
  localparam logic [1:0] MODE_COL      = 2'd2;
  localparam logic [1:0] MODE_COL_SERP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // True when the inner counter walks x (strip runs along rows).
  function automatic logic mode_is_row(input logic [1:0] mode);
    return (mode == MODE_ROW) || (mode == MODE_ROW_SERP);
  endfunction

  // True when every odd outer line runs backwards.
  function automatic logic mode_is_serp(input logic [1:0] mode);
    return (mode == MODE_ROW_SERP) || (mode == MODE_COL_SERP);
  endfunction

endpackage

// File: rtl/led_xy_map.sv
// Combinational strip-coordinate to frame-buffer address map; shared with the frame-buffer writer.
module led_xy_map
  import led_map_pkg::*;
#(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 8,
  parameter int unsigned AW   = $clog2(COLS * ROWS),
  parameter int unsigned CW   = 3
) (
  input  logic [1:0]    i_mode,
  input  logic          i_mirror_x,
  input  logic          i_mirror_y,
  input  logic [CW-1:0] i_inner,
  input  logic [CW-1:0] i_outer,
  output logic [AW-1:0] o_addr_c
);

  logic          w_row;
  logic [CW-1:0] w_inner_max;
  logic [CW-1:0] w_inner_eff;
  logic [CW-1:0] w_xs;
  logic [CW-1:0] w_ys;
  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;

  // Serpentine reversal first, then axis assignment, then mirroring, then y*COLS+x.
  always_comb begin
    w_row       = mode_is_row(i_mode);
    w_inner_max = w_row ? CW'(COLS - 1) : CW'(ROWS - 1);
    w_inner_eff = (mode_is_serp(i_mode) && i_outer[0]) ? (w_inner_max - i_inner) : i_inner;
    if (w_row) begin
      w_xs = w_inner_eff;
      w_ys = i_outer;
    end else begin
      w_xs = i_outer;
      w_ys = w_inner_eff;
    end
    w_x      = i_mirror_x ? (CW'(COLS - 1) - w_xs) : w_xs;
    w_y      = i_mirror_y ? (CW'(ROWS - 1) - w_ys) : w_ys;
    o_addr_c = AW'((32'(w_y) * 32'(COLS)) + 32'(w_x));
  end

endmodule

// File: rtl/led_addr_scan.sv
// Frame scan-address generator: walks strip positions 0..N-1 and streams mapped addresses.
module led_addr_scan
  import led_map_pkg::*;
#(
  parameter int unsigned COLS = 8,
  parameter int unsigned ROWS = 8,
  parameter int unsigned AW   = $clog2(COLS * ROWS)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          start_in,
  input  logic          abort_in,
  input  logic [1:0]    mode_in,
  input  logic          mirror_x_in,
  input  logic          mirror_y_in,
  input  logic          ready_in,
  output logic [AW-1:0] addr_out,
  output logic          valid_out,
  output logic          last_out,
  output logic          busy_out,
  output logic          done_out
);

  localparam int unsigned CW = (COLS > ROWS) ? $clog2(COLS) : $clog2(ROWS);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_mode, w_mode_nxt;
  logic          r_mirror_x, w_mirror_x_nxt;
  logic          r_mirror_y, w_mirror_y_nxt;
  logic [CW-1:0] r_inner, w_inner_nxt;
  logic [CW-1:0] r_outer, w_outer_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_last, w_last_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;

  logic [AW-1:0] w_map_addr;
  logic          w_row;
  logic [CW-1:0] w_inner_max;
  logic [CW-1:0] w_outer_max;
  logic          w_at_end;
  logic          w_load;

  led_xy_map #(
    .COLS (COLS),
    .ROWS (ROWS),
    .AW   (AW),
    .CW   (CW)
  ) u_xy_map (
    .i_mode     (r_mode),
    .i_mirror_x (r_mirror_x),
    .i_mirror_y (r_mirror_y),
    .i_inner    (r_inner),
    .i_outer    (r_outer),
    .o_addr_c   (w_map_addr)
  );

  // State, latched frame config, counters and output register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_ROW;
      r_mirror_x <= 1'b0;
      r_mirror_y <= 1'b0;
      r_inner    <= '0;
      r_outer    <= '0;
      r_addr     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_mirror_x <= w_mirror_x_nxt;
      r_mirror_y <= w_mirror_y_nxt;
      r_inner    <= w_inner_nxt;
      r_outer    <= w_outer_nxt;
      r_addr     <= w_addr_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and output-register logic; abort beats accept, start wins over abort in IDLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_mirror_x_nxt = r_mirror_x;
    w_mirror_y_nxt = r_mirror_y;
    w_inner_nxt    = r_inner;
    w_outer_nxt    = r_outer;
    w_addr_nxt     = r_addr;
    w_valid_nxt    = r_valid;
    w_last_nxt     = r_last;
    w_done_nxt     = 1'b0;

    w_row       = mode_is_row(r_mode);
    w_inner_max = w_row ? CW'(COLS - 1) : CW'(ROWS - 1);
    w_outer_max = w_row ? CW'(ROWS - 1) : CW'(COLS - 1);
    w_at_end    = (r_inner == w_inner_max) && (r_outer == w_outer_max);
    w_load      = !r_valid || ready_in;

    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          w_mode_nxt     = mode_in;
          w_mirror_x_nxt = mirror_x_in;
          w_mirror_y_nxt = mirror_y_in;
          w_inner_nxt    = '0;
          w_outer_nxt    = '0;
          w_state_nxt    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_in) begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (w_load) begin
          w_addr_nxt  = w_map_addr;
          w_valid_nxt = 1'b1;
          if (w_at_end) begin
            w_last_nxt  = 1'b1;
            w_state_nxt = ST_DRAIN;
          end else if (r_inner == w_inner_max) begin
            w_inner_nxt = '0;
            w_outer_nxt = r_outer + CW'(1);
          end else begin
            w_inner_nxt = r_inner + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (abort_in) begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (ready_in) begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign addr_out  = r_addr;
  assign valid_out = r_valid;
  assign last_out  = r_last;
  assign busy_out  = r_busy;
  assign done_out  = r_done;

endmodule

// File: tb/tb_led_addr_scan.sv
// Scoreboard bench for led_addr_scan: an 8x8 and a 4x3 instance checked against a position-based model.
module tb_led_addr_scan;

  localparam int unsigned CA = 8, RA = 8, NA = 64, AWA = 6;
  localparam int unsigned CB = 4, RB = 3, NB = 12, AWB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start_a, start_b, abort, mx, my, ready;
  logic [1:0]     mode;
  logic [AWA-1:0] addr_a;
  logic [AWB-1:0] addr_b;
  logic           valid_a, last_a, busy_a, done_a;
  logic           valid_b, last_b, busy_b, done_b;

  led_addr_scan #(.COLS(CA), .ROWS(RA)) u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_a), .abort_in(abort),
    .mode_in(mode), .mirror_x_in(mx), .mirror_y_in(my), .ready_in(ready),
    .addr_out(addr_a), .valid_out(valid_a), .last_out(last_a),
    .busy_out(busy_a), .done_out(done_a)
  );

  led_addr_scan #(.COLS(CB), .ROWS(RB)) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .abort_in(abort),
    .mode_in(mode), .mirror_x_in(mx), .mirror_y_in(my), .ready_in(ready),
    .addr_out(addr_b), .valid_out(valid_b), .last_out(last_b),
    .busy_out(busy_b), .done_out(done_b)
  );

  typedef struct {
    int unsigned addr;
    bit          last;
  } beat_t;

  beat_t qa[$], qb[$];
  beat_t ea, eb;
  int n_vec = 0, n_err = 0;
  int done_cnt_a = 0, done_cnt_b = 0, busy_cnt_a = 0;
  int beat_idx_a = 0, beat_idx_b = 0;
  int got_a[NA];
  int got_b[NB];
  bit rnd_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: strip position s -> (outer,inner) by division, serpentine, mirror, y*cols+x.
  function automatic int unsigned ref_addr(input int unsigned cols, input int unsigned rows,
                                           input int unsigned m, input bit fx, input bit fy,
                                           input int unsigned s);
    int unsigned inner_n, o, i, x, y;
    bit rowm;
    rowm    = (m < 2);
    inner_n = rowm ? cols : rows;
    o = s / inner_n;
    i = s % inner_n;
    if ((m == 1 || m == 3) && (o % 2 == 1)) i = inner_n - 1 - i;
    if (rowm) begin x = i; y = o; end
    else      begin x = o; y = i; end
    if (fx) x = cols - 1 - x;
    if (fy) y = rows - 1 - y;
    return y * cols + x;
  endfunction

  // Ready driver: always-ready or random backpressure.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor A: pop on accepted beats, check stall stability and done timing.
  bit             stall_a, exp_done_a;
  logic [AWA-1:0] hold_addr_a;
  logic           hold_last_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_a    = 1'b0;
      exp_done_a = 1'b0;
    end else begin
      if (busy_a) busy_cnt_a++;
      if (exp_done_a) begin
        check("done_a_pulse", int'(done_a), 1);
        check("busy_a_at_done", int'(busy_a), 0);
        exp_done_a = 1'b0;
      end else begin
        check("no_done_a", int'(done_a), 0);
      end
      if (stall_a && valid_a) begin
        check("hold_addr_a", int'(addr_a), int'(hold_addr_a));
        check("hold_last_a", int'(last_a), int'(hold_last_a));
      end
      stall_a     = valid_a && !ready;
      hold_addr_a = addr_a;
      hold_last_a = last_a;
      if (valid_a && ready && !abort) begin
        if (qa.size() == 0) begin
          check("extra_beat_a", 1, 0);
        end else begin
          ea = qa.pop_front();
          check("addr_a", int'(addr_a), int'(ea.addr));
          check("last_a", int'(last_a), int'(ea.last));
          if (beat_idx_a < NA) got_a[beat_idx_a] = int'(addr_a);
          beat_idx_a++;
          exp_done_a = ea.last;
        end
      end
      if (done_a) done_cnt_a++;
    end
  end

  // Monitor B: same checks for the 4x3 instance.
  bit             stall_b, exp_done_b;
  logic [AWB-1:0] hold_addr_b;
  logic           hold_last_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_b    = 1'b0;
      exp_done_b = 1'b0;
    end else begin
      if (exp_done_b) begin
        check("done_b_pulse", int'(done_b), 1);
        check("busy_b_at_done", int'(busy_b), 0);
        exp_done_b = 1'b0;
      end else begin
        check("no_done_b", int'(done_b), 0);
      end
      if (stall_b && valid_b) begin
        check("hold_addr_b", int'(addr_b), int'(hold_addr_b));
        check("hold_last_b", int'(last_b), int'(hold_last_b));
      end
      stall_b     = valid_b && !ready;
      hold_addr_b = addr_b;
      hold_last_b = last_b;
      if (valid_b && ready && !abort) begin
        if (qb.size() == 0) begin
          check("extra_beat_b", 1, 0);
        end else begin
          eb = qb.pop_front();
          check("addr_b", int'(addr_b), int'(eb.addr));
          check("last_b", int'(last_b), int'(eb.last));
          if (beat_idx_b < NB) got_b[beat_idx_b] = int'(addr_b);
          beat_idx_b++;
          exp_done_b = eb.last;
        end
      end
      if (done_b) done_cnt_b++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expected frame and pulse start on the chosen instance.
  task automatic start_frame(input bit which_b, input logic [1:0] m, input bit fx, input bit fy);
    int unsigned n;
    n    = which_b ? NB : NA;
    mode = m;
    mx   = fx;
    my   = fy;
    for (int unsigned s = 0; s < n; s++) begin
      if (which_b) qb.push_back('{addr: ref_addr(CB, RB, int'(m), fx, fy, s), last: (s == n - 1)});
      else         qa.push_back('{addr: ref_addr(CA, RA, int'(m), fx, fy, s), last: (s == n - 1)});
    end
    if (which_b) begin beat_idx_b = 0; start_b = 1'b1; end
    else begin beat_idx_a = 0; busy_cnt_a = 0; start_a = 1'b1; end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    check("busy_after_start", int'(which_b ? busy_b : busy_a), 1);
    check("no_valid_first_cycle", int'(which_b ? valid_b : valid_a), 0);
  endtask

  // Wait for done with a cycle budget; optionally disturb start/mode/mirror mid-frame.
  task automatic wait_done(input bit which_b, input int budget, input bit disturb);
    int d0, k;
    d0 = which_b ? done_cnt_b : done_cnt_a;
    k  = 0;
    while (((which_b ? done_cnt_b : done_cnt_a) == d0) && (k < budget)) begin
      if (disturb && k == 5) start_a = 1'b1;
      if (disturb && k == 6) begin
        start_a = 1'b0;
        mode    = ~mode;
        mx      = ~mx;
        my      = ~my;
      end
      tick();
      k++;
    end
    start_a = 1'b0;
    check("frame_done_seen", int'((which_b ? done_cnt_b : done_cnt_a) != d0), 1);
    check("queue_drained", which_b ? qb.size() : qa.size(), 0);
  endtask

  // Wait until instance A presents the given address.
  task automatic wait_addr_a(input int target, input int budget);
    int k;
    k = 0;
    while (!(valid_a && int'(addr_a) == target) && (k < budget)) begin
      tick();
      k++;
    end
    check("reach_addr_a", int'(k < budget), 1);
  endtask

  int exp_b43[NB] = '{0, 4, 8, 9, 5, 1, 2, 6, 10, 11, 7, 3};
  bit          rb, rx, ry;
  logic [1:0]  rm;

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    mode = 2'd0; mx = 1'b0; my = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr_a", int'(addr_a), 0);
    check("rst_valid_a", int'(valid_a), 0);
    check("rst_last_a", int'(last_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_valid_b", int'(valid_b), 0);
    rst_n = 1'b1;
    tick();

    // 8x8 ROW, always ready: 0..63, N+1 busy cycles.
    start_frame(1'b0, 2'd0, 1'b0, 1'b0);
    wait_done(1'b0, 300, 1'b0);
    check("busy_cycles_a", busy_cnt_a, NA + 1);
    check("row_s0", got_a[0], 0);
    check("row_s63", got_a[63], 63);

    // 8x8 ROW_SERP.
    start_frame(1'b0, 2'd1, 1'b0, 1'b0);
    wait_done(1'b0, 300, 1'b0);
    check("serp_s7", got_a[7], 7);
    check("serp_s8", got_a[8], 15);
    check("serp_s15", got_a[15], 8);
    check("serp_s16", got_a[16], 16);
    check("serp_s63", got_a[63], 56);

    // Mirroring.
    start_frame(1'b0, 2'd0, 1'b1, 1'b0);
    wait_done(1'b0, 300, 1'b0);
    check("mirx_s0", got_a[0], 7);
    check("mirx_s8", got_a[8], 15);
    start_frame(1'b0, 2'd0, 1'b1, 1'b1);
    wait_done(1'b0, 300, 1'b0);
    check("mirxy_s0", got_a[0], 63);

    // 4x3 COL_SERP.
    start_frame(1'b1, 2'd3, 1'b0, 1'b0);
    wait_done(1'b1, 100, 1'b0);
    for (int i = 0; i < NB; i++) check("colserp_4x3", got_b[i], exp_b43[i]);

    // Random backpressure with mid-frame start and config changes.
    rnd_ready = 1'b1;
    start_frame(1'b0, 2'd0, 1'b0, 1'b0);
    wait_done(1'b0, 2000, 1'b1);
    check("stall_s40", got_a[40], 40);
    rnd_ready = 1'b0;
    tick();

    // Abort at s=20.
    start_frame(1'b0, 2'd0, 1'b0, 1'b0);
    wait_addr_a(20, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", int'(valid_a), 0);
    check("abort_last", int'(last_a), 0);
    check("abort_busy", int'(busy_a), 0);
    qa.delete();
    repeat (4) tick();
    start_frame(1'b0, 2'd0, 1'b0, 1'b0);
    wait_done(1'b0, 300, 1'b0);
    check("after_abort_s0", got_a[0], 0);

    // Reset mid-frame at s=30.
    start_frame(1'b0, 2'd0, 1'b0, 1'b0);
    wait_addr_a(30, 100);
    rst_n = 1'b0;
    #1;
    check("midrst_addr", int'(addr_a), 0);
    check("midrst_valid", int'(valid_a), 0);
    check("midrst_last", int'(last_a), 0);
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_done", int'(done_a), 0);
    qa.delete();
    tick();
    rst_n = 1'b1;
    tick();
    start_frame(1'b0, 2'd0, 1'b0, 1'b0);
    wait_done(1'b0, 300, 1'b0);
    check("after_rst_s0", got_a[0], 0);

    // Randomized frames on either instance.
    for (int f = 0; f < 10; f++) begin
      rb        = 1'($urandom_range(0, 1));
      rm        = 2'($urandom_range(0, 3));
      rx        = 1'($urandom_range(0, 1));
      ry        = 1'($urandom_range(0, 1));
      rnd_ready = 1'($urandom_range(0, 1));
      start_frame(rb, rm, rx, ry);
      wait_done(rb, 2000, 1'b0);
    end
    rnd_ready = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
